// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared sequencer state encoding and default widths.
package cpu_ctrl_pkg;
    localparam int ADDR_W_DEF  = 10;
    localparam int STALL_W_DEF = 4;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } seq_state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode/PC side bundle for the PC sequencer.
//   master: decode/testbench side, drives addr_ins, stall_req, stall_cycles,
//           mem_req, mem_ack, halt_ins, resume (and step with PC_SEQ_STEP_EN);
//           observes pc_hold, busy, halted.
//   slave:  the sequencer itself.
interface pc_sequencer_if import cpu_ctrl_pkg::*; #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int STALL_W = STALL_W_DEF
);
    logic [ADDR_W-1:0]  addr_ins;
    logic               stall_req;
    logic [STALL_W-1:0] stall_cycles;
    logic               mem_req;
    logic               mem_ack;
    logic               halt_ins;
    logic               resume;
`ifdef PC_SEQ_STEP_EN
    logic               step;
`endif
    logic               pc_hold;
    logic               busy;
    logic               halted;
    modport master (
        output addr_ins, stall_req, stall_cycles, mem_req, mem_ack, halt_ins, resume,
`ifdef PC_SEQ_STEP_EN
        output step,
`endif
        input  pc_hold, busy, halted
    );
    modport slave (
        input  addr_ins, stall_req, stall_cycles, mem_req, mem_ack, halt_ins, resume,
`ifdef PC_SEQ_STEP_EN
        input  step,
`endif
        output pc_hold, busy, halted
    );
endinterface

// File: rtl/stall_counter.sv
// stall_counter: loadable down-counter with zero flag, falling-edge clocked.
//   clk, rst (async, active-high), load/load_val (load wins), dec (saturates at 0),
//   zero: counter value is 0.
module stall_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    end
    always_ff @(negedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: decides each falling edge whether the PC advances or holds.
//   clk, rst (async, active-high), bus (pc_sequencer_if.slave):
//   addr_ins/stall_req/stall_cycles/mem_req/mem_ack/halt_ins/resume in,
//   pc_hold (combinational), busy/halted (registered) out.
//   Optional single-step in HALT enabled by macro PC_SEQ_STEP_EN (adds bus.step).
module pc_sequencer import cpu_ctrl_pkg::*; #(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                STALL_W  = STALL_W_DEF,
    parameter logic [ADDR_W-1:0] END_ADDR = {ADDR_W{1'b1}}
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    seq_state_e state_q, state_d;
    logic       busy_q, busy_d, halted_q, halted_d;
    logic       pc_hold, cnt_load, cnt_dec, cnt_zero, end_hit, step_go;
    assign end_hit = (bus.addr_ins == END_ADDR);
`ifdef PC_SEQ_STEP_EN
    assign step_go = bus.step;
`else
    assign step_go = 1'b0;
`endif
    // The first held edge happens in RUN, so STALL covers the remaining N-1 edges.
    stall_counter #(.W(STALL_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (bus.stall_cycles - STALL_W'(2)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );
    always_comb begin
        state_d  = state_q;
        pc_hold  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.halt_ins || end_hit) begin
                    pc_hold = 1'b1;
                    state_d = HALT;
                end else if (bus.mem_req) begin
                    pc_hold = !bus.mem_ack;
                    state_d = bus.mem_ack ? RUN : MEM;
                end else if (bus.stall_req && bus.stall_cycles != '0) begin
                    pc_hold  = 1'b1;
                    cnt_load = (bus.stall_cycles > STALL_W'(1));
                    state_d  = cnt_load ? STALL : RUN;
                end
            end
            STALL: begin
                pc_hold = 1'b1;
                cnt_dec = !cnt_zero;
                state_d = cnt_zero ? RUN : STALL;
            end
            MEM: begin
                pc_hold = !bus.mem_ack;
                state_d = bus.mem_ack ? RUN : MEM;
            end
            HALT: begin
                pc_hold = !bus.resume && !step_go;
                state_d = bus.resume ? RUN : HALT;
            end
            default: state_d = RUN;
        endcase
        busy_d   = (state_d != RUN);
        halted_d = (state_d == HALT);
    end
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end
    assign bus.pc_hold = pc_hold;
    assign bus.busy    = busy_q;
    assign bus.halted  = halted_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven and directed checks of pc_sequencer with a PC model.
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pc  = '0;
    int         checks = 0;
    int         failures = 0;
    int         holds;
    logic       h;
    always #5 clk = ~clk;

    pc_sequencer_if bus();
    assign bus.addr_ins = pc;

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       sr;
        logic [3:0] n;
        logic       mr;
        logic       ma;
        logic       hi;
        logic       rs;
        logic       e_hold;
        logic       e_busy;
        logic       e_halted;
    } vec_t;
    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.stall_req = 1'b0; bus.stall_cycles = '0; bus.mem_req = 1'b0;
        bus.mem_ack = 1'b0; bus.halt_ins = 1'b0; bus.resume = 1'b0;
`ifdef PC_SEQ_STEP_EN
        bus.step = 1'b0;
`endif
    endtask

    // Samples pc_hold mid-cycle, then advances the PC model just after the falling edge.
    task automatic tick(output logic hold);
        @(posedge clk);
        hold = bus.pc_hold;
        @(negedge clk);
        #1;
        if (!hold) pc = pc + 10'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs = '{
            '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
            '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
            '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
            '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
        };
        idle();
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_halted", 32'(bus.halted), 32'd0);
        chk("reset_hold", 32'(bus.pc_hold), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            bus.stall_req = vecs[i].sr; bus.stall_cycles = vecs[i].n;
            bus.mem_req = vecs[i].mr; bus.mem_ack = vecs[i].ma;
            bus.halt_ins = vecs[i].hi; bus.resume = vecs[i].rs;
            tick(h);
            chk($sformatf("vec%0d_hold", i), 32'(h), 32'(vecs[i].e_hold));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_halted", i), 32'(bus.halted), 32'(vecs[i].e_halted));
        end
        chk("table_pc", 32'(pc), 32'd9);

        pc = 10'd5; holds = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i == 0) begin bus.stall_req = 1'b1; bus.stall_cycles = 4'd3; end
            tick(h);
            holds += int'(h);
        end
        chk("stall3_holds", 32'(holds), 32'd3);
        chk("stall3_pc", 32'(pc), 32'd6);
        idle(); tick(h);
        chk("stall3_after", 32'(h), 32'd0);

        pc = 10'd20; holds = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            bus.mem_req = 1'b1;
            bus.mem_ack = (i == 4);
            tick(h);
            holds += int'(h);
        end
        chk("mem4_holds", 32'(holds), 32'd4);
        chk("mem4_pc", 32'(pc), 32'd21);
        idle(); bus.mem_req = 1'b1; bus.mem_ack = 1'b1;
        tick(h);
        chk("mem0_hold", 32'(h), 32'd0);

        pc = 10'h012; idle(); bus.halt_ins = 1'b1;
        tick(h);
        chk("halt_enter", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 10; i++) tick(h);
        chk("halt_pc", 32'(pc), 32'h012);
        chk("halt_still", 32'(bus.halted), 32'd1);
        bus.resume = 1'b1;
        tick(h);
        chk("resume_pc", 32'(pc), 32'h013);
        chk("resume_halted", 32'(bus.halted), 32'd0);

        pc = 10'h3FE; idle();
        for (int i = 0; i < 5; i++) tick(h);
        chk("end_pc", 32'(pc), 32'h3FF);
        chk("end_halted", 32'(bus.halted), 32'd1);
        bus.resume = 1'b1;
        tick(h);
        chk("end_wrap_pc", 32'(pc), 32'h000);
        chk("end_wrap_halted", 32'(bus.halted), 32'd0);

        pc = 10'd40; idle(); bus.stall_req = 1'b1; bus.stall_cycles = 4'd4;
        tick(h);
        idle();
        chk("mid_stall_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hold", 32'(bus.pc_hold), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick(h);
        chk("post_rst_hold", 32'(h), 32'd0);
        chk("post_rst_pc", 32'(pc), 32'd41);

`ifdef PC_SEQ_STEP_EN
        pc = 10'd50; idle(); bus.halt_ins = 1'b1;
        tick(h);
        idle();
        for (int i = 0; i < 2; i++) begin
            bus.step = 1'b1; tick(h);
            bus.step = 1'b0; tick(h);
        end
        chk("step_pc", 32'(pc), 32'd52);
        chk("step_halted", 32'(bus.halted), 32'd1);
        bus.step = 1'b1; bus.resume = 1'b1;
        tick(h);
        chk("step_resume_halted", 32'(bus.halted), 32'd0);
        idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Sequencing controller for the 10-bit program counter. It decides, on every clock edge, whether the PC advances or holds, by driving the PC's `pc_hold` input. Hold sources are:
- multi-cycle execute stalls;
- data-memory wait handshakes;
- HALT instructions;
- end-of-program detection.

It sits between instruction decode and the PC, in the same clock domain and on the same edge.

## Interface
Parameters:
- `ADDR_W`, 10, PC/instruction address width.
- `STALL_W`, 4, width of the stall-length field and internal counter.
- `END_ADDR`, 10'h3FF, last legal instruction address; reaching it halts the core.

Ports:
- `clk`  in  1  system clock; all state updates on the falling edge, the same edge as the PC.
- `rst`  in  1  reset, asynchronous, active-high.
- `addr_ins`  in  ADDR_W  current PC value.
- `stall_req`  in  1  decode requests a multi-cycle execute stall.
- `stall_cycles`  in  STALL_W  number of PC edges to hold (N); sampled only with `stall_req`.
- `mem_req`  in  1  current instruction issues a data-memory access.
- `mem_ack`  in  1  data memory completes the access.
- `halt_ins`  in  1  current instruction is HALT.
- `resume`  in  1  leave HALT.
- `step`  in  1  single-step request; present only with `PC_SEQ_STEP_EN`.
- `pc_hold`  out  1  to PC; 1 = PC keeps its value at the next falling edge.
- `busy`  out  1  registered; 1 when state != RUN.
- `halted`  out  1  registered; 1 when state == HALT.

## Operation
- The FSM has 4 states: RUN, STALL, MEM, HALT. A down-counter `cnt` of width STALL_W is used in STALL.
- `pc_hold` is combinational (Mealy) from state and inputs. All other state is registered.
- **RUN**
  - Priority: `halt_ins` > end hit (`addr_ins == END_ADDR`) > `mem_req` > `stall_req`.
  - `halt_ins` or end hit: `pc_hold`=1, next state HALT.
  - `mem_req` & `mem_ack` in the same cycle (zero-wait): `pc_hold`=0, stay in RUN.
  - `mem_req` & !`mem_ack`: `pc_hold`=1, next state MEM.
  - `stall_req` & N>=2: `pc_hold`=1, `cnt` <= N-2, next state STALL.
  - `stall_req` & N==1: `pc_hold`=1 for one edge, stay in RUN.
  - `stall_req` & N==0: treated as no request.
  - Otherwise: `pc_hold`=0.
- **STALL**: `pc_hold`=1 and `cnt` decrements while `cnt`!=0. At `cnt`==0, `pc_hold`=1 for this final edge, then next state RUN. The total number of held edges equals N exactly.
- **MEM**: `pc_hold` = !`mem_ack`. `mem_ack` moves the FSM to RUN, and the PC advances on that same edge.
- **HALT**: `pc_hold`=1. `resume` gives `pc_hold`=0 and next state RUN, so the PC moves past the HALT instruction.
  - Resume from END_ADDR wraps the PC to 0. This is the natural ADDR_W wrap and is legal.
- In STALL, MEM and HALT, `halt_ins`, `stall_req` and `mem_req` are ignored; decode still presents the same instruction.
- `mem_ack` outside MEM is ignored, except for the zero-wait case in RUN.

## Timing
- Reset (async, immediate) forces:
  - state=RUN, `cnt`=0, `busy`=0, `halted`=0;
  - `pc_hold`=0 when inputs are low.
- Reset mid-STALL/MEM/HALT returns to RUN with no pending hold.
- `rst` dominates all simultaneous inputs.
- Inputs must be stable before each falling edge. `pc_hold` is valid combinationally within the same cycle.
- `busy` and `halted` change on the same falling edge as the state.
- HALT entry latency: the edge in which `halt_ins` is seen is held. `halted`=1 after that edge.

## Configuration
- `PC_SEQ_STEP_EN` defined:
  - The `step` port exists.
  - In HALT, `step`=1 (and `resume`=0) gives `pc_hold`=0 for exactly one edge; the FSM stays in HALT.
  - `step` and `resume` together: `resume` wins.
  - `step` outside HALT is ignored.
- Undefined: there is no `step` port, and HALT exits only via `resume` or `rst`.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - state typedef with encoding RUN=2'd0, STALL=2'd1, MEM=2'd2, HALT=2'd3;
  - ADDR_W and STALL_W defaults.
- One sub-module, `stall_counter`: loadable STALL_W down-counter with a zero flag, clocked on the falling edge, with async reset.

## Test plan
- Reset → release at `addr_ins`=0, no requests → `pc_hold`=0 on every edge, `busy`=0.
- Stall N=3 at `addr_ins`=5:
  - `pc_hold`=1 on exactly 3 consecutive edges, then 0;
  - the PC goes to 6 on the 4th edge.
- N=1 holds for one edge only; N=0 holds for no edges.
- Memory wait:
  - `mem_req` with `mem_ack` delayed 4 cycles → 4 held edges, advance on the ack edge;
  - `mem_req`+`mem_ack` together → no hold.
- HALT at 0x012 → `halted`=1, PC stays at 0x012 for 10 cycles. `resume` → PC 0x013, `halted`=0.
- End detect: PC reaches 0x3FF → HALT, no wrap. `resume` → PC 0x000.
- Simultaneous `halt_ins`+`mem_req` → HALT taken. `rst` asserted mid-STALL (`cnt`=2) → RUN immediately, `pc_hold`=0.
- With `PC_SEQ_STEP_EN`: two `step` pulses in HALT → PC +2, `halted` stays 1.
